// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 mouse command/response codes and controller state encoding.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT    = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_RST,
        ST_WAIT_ACK1,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_SEND_EN,
        ST_WAIT_ACK2,
        ST_PKT1,
        ST_PKT2,
        ST_PKT3,
        ST_FAIL
    } ps2_state_t;

    function automatic logic [7:0] expected_rsp(input ps2_state_t s);
        case (s)
            ST_WAIT_BAT: return RSP_BAT;
            ST_WAIT_ID:  return RSP_ID;
            default:     return RSP_ACK;
        endcase
    endfunction

endpackage

// File: rtl/ps2_mouse_ctrl.sv
// rtl/ps2_mouse_ctrl.sv - PS/2 mouse init sequencer and 3-byte movement packet assembler.
module ps2_mouse_ctrl
    import ps2_pkg::*;
#(
    parameter logic [23:0] RSP_TIMEOUT     = 24'd5_000_000,
    parameter logic [19:0] PKT_GAP_TIMEOUT = 20'd500_000,
    parameter int          MAX_RETRY       = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    input  logic       tx_idle,
    input  logic       tx_done_tick,
    output logic       rx_en,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic [8:0] xm,
    output logic [8:0] ym,
    output logic [2:0] btn,
    output logic       m_done_tick,
    output logic       init_done,
    output logic       init_err
);

    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [23:0] RSP_LAST    = RSP_TIMEOUT - 24'd1;
    localparam logic [23:0] GAP_LAST    = {4'd0, PKT_GAP_TIMEOUT} - 24'd1;

    ps2_state_t  state_q, state_d;
    logic        sent_q, sent_d;
    logic        tx_wr_q, tx_wr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [23:0] tmr_q, tmr_d;
    logic [3:0]  retry_q, retry_d;
    logic [1:0]  sgn_q, sgn_d;
    logic [2:0]  b1btn_q, b1btn_d;
    logic [7:0]  b2_q, b2_d;
    logic [8:0]  xm_q, xm_d, ym_q, ym_d;
    logic [2:0]  btn_q, btn_d;
    logic        m_done_q, m_done_d;
    logic        fail_c, timing_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sent_q    <= 1'b0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            tmr_q     <= '0;
            retry_q   <= '0;
            sgn_q     <= '0;
            b1btn_q   <= '0;
            b2_q      <= '0;
            xm_q      <= '0;
            ym_q      <= '0;
            btn_q     <= '0;
            m_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sent_q    <= sent_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            tmr_q     <= tmr_d;
            retry_q   <= retry_d;
            sgn_q     <= sgn_d;
            b1btn_q   <= b1btn_d;
            b2_q      <= b2_d;
            xm_q      <= xm_d;
            ym_q      <= ym_d;
            btn_q     <= btn_d;
            m_done_q  <= m_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sent_d    = sent_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        tmr_d     = tmr_q;
        retry_d   = retry_q;
        sgn_d     = sgn_q;
        b1btn_d   = b1btn_q;
        b2_d      = b2_q;
        xm_d      = xm_q;
        ym_d      = ym_q;
        btn_d     = btn_q;
        m_done_d  = 1'b0;
        fail_c    = 1'b0;
        timing_c  = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_SEND_RST;
            ST_SEND_RST, ST_SEND_EN: begin
                // sent_q guards the single tx_wr pulse; completion is only honoured after it
                if (!sent_q) begin
                    if (tx_idle) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = (state_q == ST_SEND_RST) ? CMD_RESET : CMD_ENABLE;
                        sent_d    = 1'b1;
                    end
                end else if (tx_done_tick) begin
                    sent_d  = 1'b0;
                    state_d = (state_q == ST_SEND_RST) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
                end
            end
            ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK2: begin
                timing_c = 1'b1;
                if (rx_done_tick) begin
                    if (rx_data != expected_rsp(state_q)) begin
                        fail_c = 1'b1;
                    end else begin
                        case (state_q)
                            ST_WAIT_ACK1: state_d = ST_WAIT_BAT;
                            ST_WAIT_BAT:  state_d = ST_WAIT_ID;
                            ST_WAIT_ID:   state_d = ST_SEND_EN;
                            default:      state_d = ST_PKT1;
                        endcase
                    end
                end else if (tmr_q == RSP_LAST) begin
                    fail_c = 1'b1;
                end
            end
            ST_PKT1: begin
                if (rx_done_tick && rx_data[3]) begin
                    sgn_d   = rx_data[5:4];
                    b1btn_d = rx_data[2:0];
                    state_d = ST_PKT2;
                end
            end
            ST_PKT2: begin
                timing_c = 1'b1;
                if (rx_done_tick) begin
                    b2_d    = rx_data;
                    state_d = ST_PKT3;
                end else if (tmr_q == GAP_LAST) begin
                    state_d = ST_PKT1;
                end
            end
            ST_PKT3: begin
                timing_c = 1'b1;
                if (rx_done_tick) begin
                    xm_d     = {sgn_q[0], b2_q};
                    ym_d     = {sgn_q[1], rx_data};
                    btn_d    = b1btn_q;
                    m_done_d = 1'b1;
                    state_d  = ST_PKT1;
                end else if (tmr_q == GAP_LAST) begin
                    state_d = ST_PKT1;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase

        if (fail_c) begin
            if (retry_q == RETRY_LIMIT) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = ST_SEND_RST;
            end
        end

        if (state_q == ST_PKT1) retry_d = '0;

        if (state_d != state_q || rx_done_tick) tmr_d = '0;
        else if (timing_c) tmr_d = tmr_q + 24'd1;
    end

    assign tx_wr       = tx_wr_q;
    assign tx_data     = tx_data_q;
    assign xm          = xm_q;
    assign ym          = ym_q;
    assign btn         = btn_q;
    assign m_done_tick = m_done_q;
    assign init_done   = (state_q == ST_PKT1) || (state_q == ST_PKT2) || (state_q == ST_PKT3);
    assign init_err    = (state_q == ST_FAIL);
    assign rx_en       = init_done || (state_q == ST_WAIT_ACK1) || (state_q == ST_WAIT_BAT)
                         || (state_q == ST_WAIT_ID) || (state_q == ST_WAIT_ACK2);

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb/tb_ps2_mouse_ctrl.sv - directed and randomized checks of ps2_mouse_ctrl against a packet model.
module tb_ps2_mouse_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_idle = 1'b1;
    logic       tx_done_tick = 1'b0;
    logic       rx_en;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic [8:0] xm, ym;
    logic [2:0] btn;
    logic       m_done_tick, init_done, init_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  tx_log[$];
    logic [20:0] pkt_log[$];

    ps2_mouse_ctrl #(
        .RSP_TIMEOUT    (24'd200),
        .PKT_GAP_TIMEOUT(20'd100),
        .MAX_RETRY      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .rx_en       (rx_en),
        .rx_data     (rx_data),
        .rx_done_tick(rx_done_tick),
        .xm          (xm),
        .ym          (ym),
        .btn         (btn),
        .m_done_tick (m_done_tick),
        .init_done   (init_done),
        .init_err    (init_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_wr) tx_log.push_back(tx_data);
        if (m_done_tick) pkt_log.push_back({btn, ym, xm});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packet meaning: signed X/Y deltas with the sign bits in byte 1, buttons in byte 1 low bits.
    function automatic logic [20:0] model_pkt(input logic [7:0] b1, input logic [7:0] b2,
                                              input logic [7:0] b3);
        int dx, dy;
        logic [8:0] ex, ey;
        dx = b1[4] ? int'(b2) - 256 : int'(b2);
        dy = b1[5] ? int'(b3) - 256 : int'(b3);
        ex = 9'(dx);
        ey = 9'(dy);
        return {b1[2:0], ey, ex};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic serve_cmd(input logic [7:0] exp, input string tag, input int budget);
        logic seen;
        int   waited;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            if (tx_wr) seen = 1'b1;
        end
        chk({tag, "_wr_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_data"}, 32'(tx_data), 32'(exp));
            tx_idle = 1'b0;
            idle(4);
            chk({tag, "_data_held"}, 32'(tx_data), 32'(exp));
            tx_done_tick = 1'b1;
            @(negedge clk);
            tx_done_tick = 1'b0;
            tx_idle      = 1'b1;
        end
    endtask

    task automatic do_init();
        serve_cmd(8'hFF, "init_ff", 100);
        idle(2); send_byte(8'hFA);
        idle(2); send_byte(8'hAA);
        idle(2); send_byte(8'h00);
        serve_cmd(8'hF4, "init_f4", 100);
        idle(2); send_byte(8'hFA);
        idle(2);
    endtask

    task automatic check_one_pkt(input string tag, input int base, input logic [20:0] exp);
        idle(5);
        chk({tag, "_count"}, 32'(pkt_log.size() - base), 32'd1);
        if (pkt_log.size() > base) chk({tag, "_value"}, 32'(pkt_log[base]), 32'(exp));
    endtask

    initial begin
        int          base;
        int          txb;
        logic [7:0]  b1, b2, b3;
        logic [20:0] exp_q[$];
        logic [20:0] last;

        rst = 1'b1;
        idle(4);
        chk("rst_tx_wr", 32'(tx_wr), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_rx_en", 32'(rx_en), 0);
        chk("rst_outputs", 32'({xm, ym, btn, m_done_tick}), 0);
        chk("rst_flags", 32'({init_done, init_err}), 0);
        rst = 1'b0;

        do_init();
        chk("init_done", 32'(init_done), 1);
        chk("init_err_low", 32'(init_err), 0);
        chk("init_rx_en", 32'(rx_en), 1);
        chk("init_tx_count", 32'(tx_log.size()), 2);

        base = pkt_log.size();
        send_byte(8'h09); send_byte(8'h05); send_byte(8'hFB);
        check_one_pkt("pkt_basic", base, model_pkt(8'h09, 8'h05, 8'hFB));

        base = pkt_log.size();
        send_byte(8'h02); send_byte(8'h28); send_byte(8'hFF); send_byte(8'h01);
        check_one_pkt("pkt_resync", base, model_pkt(8'h28, 8'hFF, 8'h01));

        base = pkt_log.size();
        send_byte(8'h08); send_byte(8'h10);
        idle(150);
        chk("gap_no_strobe", 32'(pkt_log.size() - base), 0);
        send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
        check_one_pkt("pkt_gap", base, 21'({3'b000, 9'h002, 9'h001}));

        base = pkt_log.size();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom) & 8'hF7);
            b1 = 8'($urandom) | 8'h08;
            b2 = 8'($urandom);
            b3 = 8'($urandom);
            send_byte(b1); idle($urandom_range(0, 20));
            send_byte(b2); idle($urandom_range(0, 20));
            send_byte(b3); idle($urandom_range(0, 20));
            exp_q.push_back(model_pkt(b1, b2, b3));
        end
        idle(5);
        chk("rand_count", 32'(pkt_log.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < pkt_log.size())
                chk($sformatf("rand_pkt%0d", i), 32'(pkt_log[base + i]), 32'(exp_q[i]));
        end
        last = exp_q[exp_q.size() - 1];
        idle(50);
        chk("hold_last_pkt", 32'({btn, ym, xm}), 32'(last));

        base = pkt_log.size();
        send_byte(8'h09); send_byte(8'h05);
        idle(2);
        rst = 1'b1;
        idle(3);
        chk("midrst_outputs", 32'({xm, ym, btn, m_done_tick}), 0);
        chk("midrst_flags", 32'({init_done, init_err, rx_en, tx_wr}), 0);
        chk("midrst_tx_data", 32'(tx_data), 0);
        rst = 1'b0;
        txb = tx_log.size();

        serve_cmd(8'hFF, "resend_ff", 100);
        idle(2); send_byte(8'hFE);
        serve_cmd(8'hFF, "retry1_ff", 100);
        serve_cmd(8'hFF, "retry2_ff", 400);
        idle(2); send_byte(8'hFE);
        idle(5);
        chk("fail_init_err", 32'(init_err), 1);
        chk("fail_init_done", 32'(init_done), 0);
        chk("fail_rx_en", 32'(rx_en), 0);
        idle(400);
        chk("fail_tx_count", 32'(tx_log.size() - txb), 3);
        chk("fail_err_sticky", 32'(init_err), 1);
        chk("midrst_no_strobe", 32'(pkt_log.size() - base), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
